// File: rtl/vs_atom_selector.sv
// vs_atom_selector: per OMP iteration, scans the inner-product RAM for the largest |x| among
// columns not yet in the support, then appends the winning column to the support list/mask.
module vs_atom_selector #(
  parameter int COLUMNS           = 256,
  parameter int MAX_SUPPORT       = 64,
  parameter int CW                = 9,
  parameter int FP_DATA_BUS_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         clear_support,
  output logic [7:0]                   read_addr,
  input  logic [FP_DATA_BUS_WIDTH-1:0] read_data,
  output logic                         done,
  output logic                         none_found,
  output logic [7:0]                   selected_index,
  output logic [FP_DATA_BUS_WIDTH-1:0] selected_value,
  output logic [CW-1:0]                support_count,
  output logic                         support_full,
  input  logic [7:0]                   support_rd_addr,
  output logic [7:0]                   support_rd_index
);
  localparam int DW = FP_DATA_BUS_WIDTH;
  localparam int IW = $clog2(COLUMNS);
  localparam int SW = MAX_SUPPORT > 1 ? $clog2(MAX_SUPPORT) : 1;
  localparam logic [7:0] LAST = 8'(COLUMNS - 1);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, REPORT} state_t;
  state_t state, state_d;
  logic primed, best_valid;
  logic [7:0] eval_col, best_index;
  logic [DW-1:0] rd_abs, best_abs, best_value;
  logic [COLUMNS-1:0] mask;
  logic [7:0] list [MAX_SUPPORT];
  logic better, last_eval, win;
  // the most negative code has no positive twin, so its magnitude saturates
  assign rd_abs = !read_data[DW-1] ? read_data :
                  read_data == {1'b1, {(DW-1){1'b0}}} ? {1'b0, {(DW-1){1'b1}}} : -read_data;
  assign better = primed && !mask[eval_col[IW-1:0]] && (!best_valid || rd_abs > best_abs);
  assign last_eval = primed && eval_col == LAST;
  assign win = best_valid && best_abs != '0;
  assign done = state == REPORT;
  assign support_full = support_count == CW'(MAX_SUPPORT);
  assign support_rd_index = 32'(support_rd_addr) < 32'(support_count) ? list[support_rd_addr[SW-1:0]] : 8'd0;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = (start && !clear_support) ? (support_full ? COMMIT : SCAN) : IDLE;
      SCAN:    state_d = last_eval ? COMMIT : SCAN;
      COMMIT:  state_d = REPORT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      read_addr      <= '0;
      primed         <= 1'b0;
      eval_col       <= '0;
      best_valid     <= 1'b0;
      best_abs       <= '0;
      best_index     <= '0;
      best_value     <= '0;
      mask           <= '0;
      none_found     <= 1'b0;
      selected_index <= '0;
      selected_value <= '0;
      support_count  <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (clear_support) begin
            mask          <= '0;
            support_count <= '0;
          end else if (start) begin
            read_addr  <= '0;
            primed     <= 1'b0;
            best_valid <= 1'b0;
            best_abs   <= '0;
            none_found <= 1'b0;
          end
        end
        SCAN: begin
          // data arrives one cycle after its address, so evaluate the previous read_addr
          read_addr <= read_addr == LAST ? read_addr : read_addr + 8'd1;
          eval_col  <= read_addr;
          primed    <= 1'b1;
          if (better) begin
            best_valid <= 1'b1;
            best_abs   <= rd_abs;
            best_index <= eval_col;
            best_value <= read_data;
          end
        end
        COMMIT: begin
          if (win) begin
            mask[best_index[IW-1:0]] <= 1'b1;
            support_count            <= support_count + 1'b1;
            selected_index           <= best_index;
            selected_value           <= best_value;
            none_found               <= 1'b0;
          end else begin
            none_found <= 1'b1;
          end
        end
        default: read_addr <= '0;
      endcase
    end
  end
  always_ff @(posedge clock)
    if (state == COMMIT && win) list[support_count[SW-1:0]] <= best_index;
endmodule

// File: tb/tb_vs_atom_selector.sv
// tb_vs_atom_selector: randomized + directed scans against a scoreboard fed by an argmax reference model.
module tb_vs_atom_selector;
  localparam int C = 8, K = 3, CW = 4;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, clear_support = 1'b0;
  logic [7:0] read_addr, selected_index, support_rd_index;
  logic [7:0] support_rd_addr = 8'd0;
  logic [31:0] read_data, selected_value;
  logic done, none_found, support_full;
  logic [CW-1:0] support_count;
  logic [31:0] ram [C];
  int cyc = 0, tests = 0, fails = 0, dones = 0;
  typedef struct {int s; int lat; bit nf; logic [7:0] idx; logic [31:0] val; int cnt;} exp_t;
  exp_t sb[$];
  bit m_mask [C];
  int m_list[$];
  logic [7:0] m_idx = 8'd0;
  logic [31:0] m_val = 32'd0;

  vs_atom_selector #(.COLUMNS(C), .MAX_SUPPORT(K), .CW(CW), .FP_DATA_BUS_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .clear_support(clear_support),
    .read_addr(read_addr), .read_data(read_data), .done(done), .none_found(none_found),
    .selected_index(selected_index), .selected_value(selected_value),
    .support_count(support_count), .support_full(support_full),
    .support_rd_addr(support_rd_addr), .support_rd_index(support_rd_index));

  always #5 clock = ~clock;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    read_data <= ram[read_addr[2:0]];
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
    end
  endtask

  // reference: argmax of saturated magnitude over unmasked columns, first index wins ties
  function automatic exp_t model(input int s);
    exp_t e;
    longint best = -1, a;
    int bi = 0;
    e.s = s;
    e.lat = (m_list.size() == K) ? 2 : C + 3;
    if (m_list.size() < K)
      for (int c = 0; c < C; c++)
        if (!m_mask[c]) begin
          a = longint'($signed(ram[c]));
          a = a < 0 ? -a : a;
          if (a > 64'h7FFFFFFF) a = 64'h7FFFFFFF;
          if (a > best) begin best = a; bi = c; end
        end
    if (best > 0) begin
      m_mask[bi] = 1'b1;
      m_list.push_back(bi);
      m_idx = 8'(bi);
      m_val = ram[bi];
      e.nf = 1'b0;
    end else e.nf = 1'b1;
    e.idx = m_idx;
    e.val = m_val;
    e.cnt = m_list.size();
    return e;
  endfunction

  task automatic model_clear();
    foreach (m_mask[c]) m_mask[c] = 1'b0;
    m_list.delete();
  endtask

  always @(negedge clock)
    if (!reset && done) begin
      exp_t e;
      dones++;
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("done_latency", 64'(cyc - e.s), 64'(e.lat));
        chk("none_found", 64'(none_found), 64'(e.nf));
        chk("selected_index", 64'(selected_index), 64'(e.idx));
        chk("selected_value", 64'(selected_value), 64'(e.val));
        chk("support_count", 64'(support_count), 64'(e.cnt));
        chk("support_full", 64'(support_full), 64'(e.cnt == K));
      end
    end

  task automatic scan();
    int s, d;
    bit quiet = 1'b1;
    exp_t e;
    @(negedge clock);
    start = 1'b1;
    s = cyc;
    e = model(s);
    sb.push_back(e);
    d = dones;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 40 && dones == d; i++) begin
      if (read_addr != 8'd0) quiet = 1'b0;
      @(negedge clock);
    end
    chk("done_seen", 64'(dones != d), 64'd1);
    if (e.lat == 2) chk("full_no_reads", 64'(quiet), 64'd1);
    for (int a = 0; a <= K; a++) begin
      support_rd_addr = 8'(a);
      #1;
      chk("support_list", 64'(support_rd_index), 64'(a < m_list.size() ? m_list[a] : 0));
    end
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear_support = 1'b1;
    @(negedge clock);
    clear_support = 1'b0;
    model_clear();
    chk("clear_count", 64'(support_count), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_read_addr"}, 64'(read_addr), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_none_found"}, 64'(none_found), 64'd0);
    chk({tag, "_sel_index"}, 64'(selected_index), 64'd0);
    chk({tag, "_sel_value"}, 64'(selected_value), 64'd0);
    chk({tag, "_count"}, 64'(support_count), 64'd0);
    chk({tag, "_full"}, 64'(support_full), 64'd0);
  endtask

  initial begin
    int v;
    foreach (ram[c]) ram[c] = 32'd0;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    ram = '{32'd5, -32'sd20, 32'd7, 32'd0, 32'd19, -32'sd3, 32'd2, 32'd1};
    repeat (4) scan();
    do_clear();
    ram = '{32'd0, 32'd9, -32'sd9, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0};
    repeat (2) scan();
    do_clear();
    ram = '{32'h7FFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h80000000, 32'd0};
    scan();
    do_clear();
    foreach (ram[c]) ram[c] = 32'd0;
    scan();
    ram = '{32'd5, -32'sd20, 32'd7, 32'd0, 32'd19, -32'sd3, 32'd2, 32'd1};
    scan();
    @(negedge clock);
    start = 1'b1;
    clear_support = 1'b1;
    @(negedge clock);
    start = 1'b0;
    clear_support = 1'b0;
    model_clear();
    repeat (16) @(negedge clock);
    chk("clear_start_count", 64'(support_count), 64'd0);
    scan();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_zero("abort");
    reset = 1'b0;
    model_clear();
    m_idx = 8'd0;
    m_val = 32'd0;
    repeat (14) @(negedge clock);
    scan();
    for (int it = 0; it < 40; it++) begin
      if (m_list.size() == K ? $urandom_range(0, 1) == 1 : $urandom_range(0, 4) == 0) do_clear();
      v = $urandom_range(0, 2);
      foreach (ram[c]) begin
        if (v == 0) ram[c] = $urandom;
        else if (v == 1) ram[c] = 32'(int'($urandom_range(0, 6)) - 3);
        else ram[c] = $urandom_range(0, 5) == 0 ? ($urandom_range(0, 1) == 1 ? 32'h80000000 : 32'h7FFFFFFF) : 32'd0;
      end
      scan();
    end
    repeat (4) @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
